// File: rtl/reg_file_loader_if.sv
// rtl/reg_file_loader_if.sv - Start/stream/RegFile write-port bundle for reg_file_loader
interface reg_file_loader_if #(
   parameter int W = 8,
   parameter int A = 2
);
   logic         Start;
   logic         Mode;
   logic         InValid;
   logic [W-1:0] InData;
   logic         InReady;
   logic         WriteEn;
   logic [A-1:0] Waddr;
   logic [W-1:0] DataIn;
   logic         Busy;
   logic         Done;
   logic [A:0]   Count;

   // The loader drives the RegFile write port and the status outputs.
   modport master (
      input  Start, Mode, InValid, InData,
      output InReady, WriteEn, Waddr, DataIn, Busy, Done, Count
   );

   // Requester / stream source / RegFile side.
   modport slave (
      output Start, Mode, InValid, InData,
      input  InReady, WriteEn, Waddr, DataIn, Busy, Done, Count
   );
endinterface

// File: rtl/reg_file_loader.sv
// rtl/reg_file_loader.sv - RegFile write-side master: stream LOAD or zero CLEAR of all registers
module reg_file_loader #(
   parameter int W = 8,
   parameter int A = 2
) (
   input logic              Clk,
   input logic              Reset,
   reg_file_loader_if.master bus
);
   localparam int DEPTH = 2 ** A;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR, S_DONE} state_t;

   state_t       state_q, state_d;
   logic [A-1:0] ptr_q, ptr_d;
   logic         we_q, we_d;
   logic [A-1:0] waddr_q, waddr_d;
   logic [W-1:0] data_q, data_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [A:0]   count_q, count_d;

   logic         issue;
   logic         last;

   // A write is issued on every CLEAR cycle and on every accepted LOAD beat.
   assign issue = (state_q == S_CLEAR) || ((state_q == S_LOAD) && bus.InValid);
   assign last  = (ptr_q == A'(DEPTH - 1));

   // Next-state and next-output computation; Waddr/DataIn hold when no write.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               ptr_d   = '0;
               count_d = '0;
               state_d = bus.Mode ? S_CLEAR : S_LOAD;
            end
         end
         S_LOAD, S_CLEAR: begin
            if (issue) begin
               we_d    = 1'b1;
               waddr_d = ptr_q;
               data_d  = (state_q == S_LOAD) ? bus.InData : '0;
               ptr_d   = ptr_q + 1'b1;
               count_d = (count_q == (A+1)'(DEPTH)) ? count_q : count_q + 1'b1;
               if (last) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; reset abandons any run in progress.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   assign bus.InReady = (state_q == S_LOAD);
   assign bus.WriteEn = we_q;
   assign bus.Waddr   = waddr_q;
   assign bus.DataIn  = data_q;
   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.Count   = count_q;
endmodule

// File: tb/tb_reg_file_loader.sv
// tb/tb_reg_file_loader.sv - self-checking bench for reg_file_loader
module tb_reg_file_loader;
   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   exp_t q[$];
   logic [7:0] beats[4];

   reg_file_loader_if #(.W(8), .A(2)) bus();

   reg_file_loader #(.W(8), .A(2)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every observed write must match the oldest expected write; Done only with the final one.
   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.WriteEn === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("waddr", 32'(bus.Waddr), 32'(e.addr));
            check("datain", 32'(bus.DataIn), 32'(e.data));
            check("done_at_write", 32'(bus.Done), 32'(e.last));
         end
      end else begin
         check("done_without_write", 32'(bus.Done), 32'd0);
      end
   end

   task automatic load_run(input int gap, input bit poke_start);
      bus.Start = 1'b1;
      bus.Mode  = 1'b0;
      step();
      bus.Start = 1'b0;
      check("load_busy_rise", 32'(bus.Busy), 32'd1);
      check("load_inready", 32'(bus.InReady), 32'd1);
      check("load_no_write_yet", 32'(bus.WriteEn), 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.InValid = 1'b1;
         bus.InData  = beats[i];
         q.push_back('{2'(i), beats[i], (i == 3)});
         if (poke_start && i == 1) begin
            bus.Start = 1'b1;
            bus.Mode  = 1'b1;
         end
         step();
         bus.Start   = 1'b0;
         bus.InValid = 1'b0;
         check("load_count", 32'(bus.Count), 32'(i + 1));
         if (i < 3) begin
            for (int g = 0; g < gap; g++) begin
               step();
               check("gap_no_write", 32'(bus.WriteEn), 32'd0);
               check("gap_waddr_hold", 32'(bus.Waddr), 32'(i));
            end
         end
      end
      check("done_pulse", 32'(bus.Done), 32'd1);
      check("done_write", 32'(bus.WriteEn), 32'd1);
      check("done_busy", 32'(bus.Busy), 32'd1);
      check("done_inready", 32'(bus.InReady), 32'd0);
      check("done_count", 32'(bus.Count), 32'd4);
      if (poke_start) begin
         bus.Start = 1'b1;
         bus.Mode  = 1'b1;
      end
      step();
      bus.Start = 1'b0;
      check("idle_busy", 32'(bus.Busy), 32'd0);
      check("idle_write", 32'(bus.WriteEn), 32'd0);
      check("idle_done", 32'(bus.Done), 32'd0);
      check("idle_count_hold", 32'(bus.Count), 32'd4);
      check("load_all_written", 32'(q.size()), 32'd0);
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      bus.Start   = 1'b0;
      bus.Mode    = 1'b0;
      bus.InValid = 1'b0;
      bus.InData  = 8'h00;

      // 1: reset state, then idle with no writes
      step();
      step();
      check("rst_writeen", 32'(bus.WriteEn), 32'd0);
      check("rst_waddr", 32'(bus.Waddr), 32'd0);
      check("rst_datain", 32'(bus.DataIn), 32'd0);
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_done", 32'(bus.Done), 32'd0);
      check("rst_count", 32'(bus.Count), 32'd0);
      check("rst_inready", 32'(bus.InReady), 32'd0);
      rst = 1'b0;
      bus.InValid = 1'b1;
      bus.InData  = 8'h5a;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_writeen", 32'(bus.WriteEn), 32'd0);
      end
      bus.InValid = 1'b0;

      // 2: back-to-back LOAD
      beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
      load_run(0, 1'b0);

      // 3: LOAD with two idle cycles between beats
      beats[0] = 8'ha1; beats[1] = 8'hb2; beats[2] = 8'hc3; beats[3] = 8'hd4;
      load_run(2, 1'b0);

      // 4: CLEAR ignores the stream and writes zeros for exactly four cycles
      bus.Start   = 1'b1;
      bus.Mode    = 1'b1;
      bus.InValid = 1'b1;
      bus.InData  = 8'hff;
      step();
      bus.Start = 1'b0;
      for (int i = 0; i < 4; i++) q.push_back('{2'(i), 8'h00, (i == 3)});
      check("clr_busy_rise", 32'(bus.Busy), 32'd1);
      check("clr_count_cleared", 32'(bus.Count), 32'd0);
      check("clr_inready", 32'(bus.InReady), 32'd0);
      check("clr_latency", 32'(bus.WriteEn), 32'd0);
      step();
      check("clr_first_write", 32'(bus.WriteEn), 32'd1);
      step();
      step();
      step();
      check("clr_done", 32'(bus.Done), 32'd1);
      check("clr_count", 32'(bus.Count), 32'd4);
      step();
      bus.InValid = 1'b0;
      check("clr_idle_write", 32'(bus.WriteEn), 32'd0);
      check("clr_idle_busy", 32'(bus.Busy), 32'd0);
      check("clr_all_written", 32'(q.size()), 32'd0);

      // 5: Start during LOAD and in the DONE cycle is ignored
      beats[0] = 8'h01; beats[1] = 8'h02; beats[2] = 8'h03; beats[3] = 8'h04;
      load_run(0, 1'b1);
      step();
      check("no_restart_busy", 32'(bus.Busy), 32'd0);
      check("no_restart_write", 32'(bus.WriteEn), 32'd0);
      check("no_restart_count", 32'(bus.Count), 32'd4);

      // 6: reset mid-LOAD, then a fresh LOAD starts at address 0
      bus.Start = 1'b1;
      bus.Mode  = 1'b0;
      step();
      bus.Start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.InValid = 1'b1;
         bus.InData  = 8'h70 + 8'(i);
         q.push_back('{2'(i), 8'h70 + 8'(i), 1'b0});
         step();
      end
      bus.InValid = 1'b0;
      check("pre_rst_count", 32'(bus.Count), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_writeen", 32'(bus.WriteEn), 32'd0);
      check("mid_rst_count", 32'(bus.Count), 32'd0);
      check("mid_rst_busy", 32'(bus.Busy), 32'd0);
      check("mid_rst_inready", 32'(bus.InReady), 32'd0);
      check("mid_rst_queue", 32'(q.size()), 32'd0);
      step();
      check("post_rst_idle", 32'(bus.WriteEn), 32'd0);
      beats[0] = 8'h9c; beats[1] = 8'h8d; beats[2] = 8'h7e; beats[3] = 8'h6f;
      load_run(0, 1'b0);

      step();
      check("final_queue_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
